// File: rtl/spi_ram_master_if.sv
// -----------------------------------------------------------------------------
// spi_ram_master_if
// Host command bus plus SPI serial pins of the SPI/RAM host-side sequencer.
//   cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_wdata : parallel host command
//   done/rd_data/busy                              : completion and read result
//   SS_n/MOSI/MISO                                 : SPI pins toward the slave
// Modports:
//   master : the sequencer itself (drives SS_n/MOSI and the status outputs)
//   slave  : the environment around it (host plus SPI slave driving MISO)
// -----------------------------------------------------------------------------
interface spi_ram_master_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_wr;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic [7:0]           cmd_wdata;
  logic                 done;
  logic [7:0]           rd_data;
  logic                 busy;
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, MISO,
    output cmd_ready, done, rd_data, busy, SS_n, MOSI
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, MISO,
    input  cmd_ready, done, rd_data, busy, SS_n, MOSI
  );
endinterface

// File: rtl/spi_ram_master.sv
// -----------------------------------------------------------------------------
// spi_ram_master
// Turns one host command (write byte / read byte) into two 10-bit SPI frames,
// {cmd[1:0], payload[7:0]}, sent MSB first: an address frame then a data frame.
// A read data frame is followed by RD_WAIT idle clocks and 8 MISO samples.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : spi_ram_master_if.master (host command bus + SPI pins)
// Parameters:
//   ADDR_SIZE  : host address width (<= 8), zero-extended into the payload
//   RD_WAIT    : clocks between last MOSI bit of a read frame and first sample
//   GAP_CYCLES : clocks SS_n stays high between frames and after the last one
// -----------------------------------------------------------------------------
module spi_ram_master #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_WAIT    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_ram_master_if.master  bus
);

  // One phase counter serves every timed state, so size it for the longest.
  localparam int CNT_MAX = (RD_WAIT > 10)
                         ? ((GAP_CYCLES > RD_WAIT) ? GAP_CYCLES : RD_WAIT)
                         : ((GAP_CYCLES > 10) ? GAP_CYCLES : 10);
  localparam int CNT_W = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(9);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_WAIT,
    ST_CAPTURE,
    ST_GAP
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic                 frame_b;      // 0: address frame, 1: data frame
  logic                 wr_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [7:0]           wdata_q;
  logic [7:0]           shift_in;
  logic [7:0]           rd_q;

  logic [1:0]           frame_cmd;
  logic [7:0]           frame_payload;
  logic [9:0]           frame;
  logic [3:0]           bit_idx;
  logic                 ss_n_c, mosi_c, done_c;

  // Command codes: write A=00, write B=01, read A=10, read B=11.
  assign frame_cmd     = {~wr_q, frame_b};
  assign frame_payload = frame_b ? (wr_q ? wdata_q : 8'h00) : 8'(addr_q);
  assign frame         = {frame_cmd, frame_payload};
  assign bit_idx       = 4'd9 - cnt[3:0];

  // NOTE: every output of the combinational block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    ss_n_c  = 1'b1;
    mosi_c  = 1'b0;
    done_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) state_n = ST_START;
      end
      ST_START: begin
        ss_n_c  = 1'b0;
        mosi_c  = frame[9];
        state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        ss_n_c = 1'b0;
        mosi_c = frame[bit_idx];
        if (cnt == SHIFT_LAST) state_n = (frame_b && !wr_q) ? ST_WAIT : ST_GAP;
      end
      ST_WAIT: begin
        ss_n_c = 1'b0;
        if (cnt == WAIT_LAST) state_n = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        ss_n_c = 1'b0;
        if (cnt == CAP_LAST) state_n = ST_GAP;
      end
      ST_GAP: begin
        done_c = frame_b && (cnt == '0);
        if (cnt == GAP_LAST) state_n = frame_b ? ST_IDLE : ST_START;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for all registers, so each one samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      frame_b  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      shift_in <= 8'h00;
      rd_q     <= 8'h00;
    end else begin
      state <= state_n;
      // Counter restarts on every state change and counts cycles within a state.
      cnt   <= (state_n != state) ? '0 : cnt + 1'b1;

      if (state == ST_IDLE && bus.cmd_valid) begin
        wr_q    <= bus.cmd_wr;
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
        frame_b <= 1'b0;
      end
      if (state == ST_GAP && state_n == ST_START) frame_b <= 1'b1;

      if (state == ST_CAPTURE) begin
        shift_in <= {shift_in[6:0], bus.MISO};
        // Publish on the final sample so rd_data is valid alongside done.
        if (state_n == ST_GAP) rd_q <= {shift_in[6:0], bus.MISO};
      end
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.SS_n      = ss_n_c;
  assign bus.MOSI      = mosi_c;
  assign bus.done      = done_c;
  assign bus.rd_data   = rd_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_master
// Directed bench for spi_ram_master. Stimulus pushes expected frames and done
// events into queues; negedge monitors (slave/RAM model, timeline, done) pop
// and compare. A second instance (ADDR_SIZE=4, RD_WAIT=3) covers the narrow
// address and longer read wait.
// -----------------------------------------------------------------------------
module tb_spi_ram_master;
  localparam int RD_WAIT = 2;
  localparam int GAP     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_ram_master_if #(.ADDR_SIZE(8)) bus ();
  spi_ram_master_if #(.ADDR_SIZE(4)) bus4 ();

  spi_ram_master u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  spi_ram_master #(.ADDR_SIZE(4), .RD_WAIT(3)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  typedef struct {
    logic [9:0] word;
    int         start;
  } frame_t;

  typedef struct {
    bit         rd;
    logic [7:0] data;
    int         at;
  } done_t;

  frame_t frame_q[$];
  done_t  done_q[$];
  done_t  q4[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc    = -1000;
  int acc4   = -1000;
  int acc_cnt = 0;
  bit active = 1'b0;
  bit act_rd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle count and acceptance bookkeeping.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      active = 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc    = cyc;
        act_rd = !bus.cmd_wr;
        active = 1'b1;
        acc_cnt++;
      end
      if (bus4.cmd_valid && bus4.cmd_ready) acc4 = cyc;
    end
  end

  // Timeline monitor: SS_n windows, idle MOSI, cmd_ready/busy.
  int rel, b_end, fin;
  bit exp_ss, idle;
  always @(negedge clk) begin
    if (!rst) begin
      rel   = cyc - acc + 1;
      b_end = act_rd ? 24 + RD_WAIT + 8 : 24;
      fin   = b_end + GAP + 1;
      idle  = !active || rel >= fin;
      exp_ss = !(active && ((rel >= 1 && rel <= 11) || (rel >= 14 && rel <= b_end)));
      check("ss_n", bus.SS_n, exp_ss);
      if (exp_ss) check("mosi_idle", bus.MOSI, 1'b0);
      check("cmd_ready", bus.cmd_ready, idle);
      check("busy", bus.busy, !idle);
    end
  end

  // Done monitor.
  done_t d;
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        d = done_q.pop_front();
        check("done_cycle", cyc - acc + 1, d.at);
        if (d.rd) check("rd_data", bus.rd_data, d.data);
      end
    end
  end

  // SPI slave + RAM model: decodes frames, drives MISO for read data frames.
  logic [7:0]  mem [256];
  logic [10:0] sh = '0;
  logic [7:0]  a_lat = 8'h00;
  int          k = 0, f_start = 0, j;
  bit          rd_b = 1'b0;
  frame_t      f;
  always @(negedge clk) begin
    if (rst || bus.SS_n) begin
      k    = 0;
      rd_b = 1'b0;
    end else begin
      k++;
      sh = {sh[9:0], bus.MOSI};
      if (k == 1) f_start = cyc - acc + 1;
      if (k == 11) begin
        if (frame_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          f = frame_q.pop_front();
          check("frame_word", sh[9:0], f.word);
          check("lead_bit", sh[10], f.word[9]);
          check("frame_start", f_start, f.start);
        end
        case (sh[9:8])
          2'b00, 2'b10: a_lat = sh[7:0];
          2'b01:        mem[a_lat] = sh[7:0];
          default:      rd_b = 1'b1;
        endcase
      end
    end
    j = k - (12 + RD_WAIT);
    if (rd_b && j >= 0 && j <= 7) bus.MISO = mem[a_lat][7 - j];
    else                          bus.MISO = 1'($urandom_range(1, 0));
  end

  // Monitor for the ADDR_SIZE=4 / RD_WAIT=3 instance.
  localparam logic [7:0] PAT4 = 8'h5A;
  int          rel4;
  logic [10:0] sh4 = '0;
  done_t       d4;
  always @(negedge clk) begin
    rel4 = cyc - acc4 + 1;
    // Outside the expected capture window drive 1 so early/late sampling shows.
    if (rel4 >= 28 && rel4 <= 35) bus4.MISO = PAT4[7 - (rel4 - 28)];
    else                          bus4.MISO = 1'b1;
    if (!rst) begin
      if (rel4 == 1) check("dut4_ss_low", bus4.SS_n, 1'b0);
      if (rel4 >= 1 && rel4 <= 11) sh4 = {sh4[9:0], bus4.MOSI};
      if (rel4 == 11 && q4.size() != 0) begin
        check("dut4_frame_a", sh4[9:0], {2'b10, 8'h0F});
        check("dut4_lead_bit", sh4[10], 1'b1);
      end
      if (bus4.done) begin
        if (q4.size() == 0) begin
          check("dut4_unexpected_done", 1, 0);
        end else begin
          d4 = q4.pop_front();
          check("dut4_done_cycle", rel4, d4.at);
          check("dut4_rd_data", bus4.rd_data, d4.data);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic expect_cmd(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                            input logic [7:0] rexp);
    frame_t fa, fb;
    done_t  dn;
    fa.word  = {(wr ? 2'b00 : 2'b10), addr};
    fa.start = 1;
    fb.word  = wr ? {2'b01, data} : {2'b11, 8'h00};
    fb.start = 14;
    dn.rd    = !wr;
    dn.data  = rexp;
    dn.at    = wr ? 25 : 25 + RD_WAIT + 8;
    frame_q.push_back(fa);
    frame_q.push_back(fb);
    done_q.push_back(dn);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", bus.cmd_ready, 1'b1);
  endtask

  task automatic issue(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                       input logic [7:0] rexp);
    wait_ready();
    expect_cmd(wr, addr, data, rexp);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((done_q.size() != 0 || !bus.cmd_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", done_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n0, t1, n;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_wr     = 1'b0;
    bus.cmd_addr   = 8'h00;
    bus.cmd_wdata  = 8'h00;
    bus4.cmd_valid = 1'b0;
    bus4.cmd_wr    = 1'b0;
    bus4.cmd_addr  = 4'h0;
    bus4.cmd_wdata = 8'h00;
    #1;
    check("rst_ss_n", bus.SS_n, 1'b1);
    check("rst_mosi", bus.MOSI, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Write 3C <- A5, then read it back.
    issue(1'b1, 8'h3C, 8'hA5, 8'h00);
    wait_idle();
    check("mem_3c", mem[8'h3C], 8'hA5);
    issue(1'b0, 8'h3C, 8'h00, 8'hA5);
    wait_idle();

    // Held cmd_valid with two commands queued by the host.
    wait_ready();
    expect_cmd(1'b1, 8'h01, 8'h11, 8'h00);
    expect_cmd(1'b0, 8'h01, 8'h00, 8'h11);
    n0 = acc_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 8'h01;
    bus.cmd_wdata = 8'h11;
    @(negedge clk);
    check("held_first_accept", acc_cnt, n0 + 1);
    t1 = acc;
    bus.cmd_wr    = 1'b0;
    bus.cmd_wdata = 8'hEE;
    n = 0;
    while (acc_cnt < n0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("held_second_gap", acc - t1, 27);
    bus.cmd_valid = 1'b0;
    wait_idle();

    // cmd_valid pulsed while busy must be ignored.
    issue(1'b1, 8'h22, 8'h33, 8'h00);
    repeat (4) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 8'h44;
    bus.cmd_wdata = 8'h99;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_idle();
    issue(1'b0, 8'h22, 8'h00, 8'h33);
    wait_idle();

    // Reset in the middle of a read aborts it with no done pulse.
    issue(1'b0, 8'h3C, 8'h00, 8'hA5);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ss_n", bus.SS_n, 1'b1);
    check("midrst_mosi", bus.MOSI, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_rd_data", bus.rd_data, 8'h00);
    check("midrst_cmd_ready", bus.cmd_ready, 1'b1);
    frame_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_rd_data", bus.rd_data, 8'h00);

    // Narrow address, longer read wait on the second instance.
    begin
      done_t e4;
      e4.rd   = 1'b1;
      e4.data = PAT4;
      e4.at   = 25 + 3 + 8;
      q4.push_back(e4);
    end
    bus4.cmd_valid = 1'b1;
    bus4.cmd_wr    = 1'b0;
    bus4.cmd_addr  = 4'hF;
    @(negedge clk);
    bus4.cmd_valid = 1'b0;
    n = 0;
    while (q4.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("dut4_done_timeout", q4.size(), 0);

    repeat (5) @(negedge clk);
    check("frames_left", frame_q.size(), 0);
    check("dones_left", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
Host-side sequencer that drives the SPI slave + RAM subsystem over its serial pins (MOSI, SS_n, MISO) from the same system clock. Converts one parallel host command (write byte / read byte) into the required two-frame SPI command sequence: address frame, then data frame. For reads it also captures the returned byte from MISO. Used as the on-chip master in front of the SPI/RAM wrapper, and as the reference master in its bench.

Parameters:
ADDR_SIZE, 8, host address width; must be <= 8; zero-extended into the 8-bit frame payload.
RD_WAIT, 2, clocks between the last MOSI bit of a read-data frame and the first MISO sample; must be >= 1.
GAP_CYCLES, 2, clocks SS_n is held high between frames and after the final frame; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
cmd_valid  input  1  host command request.
cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
cmd_wr  input  1  1 = write, 0 = read.
cmd_addr  input  ADDR_SIZE  target RAM address.
cmd_wdata  input  8  write data; ignored for reads.
done  output  1  one-cycle completion pulse, for writes and reads.
rd_data  output  8  last read byte; valid when done pulses on a read; held until the next read completes.
busy  output  1  inverse of cmd_ready.
SS_n  output  1  slave select, active low.
MOSI  output  1  serial data to slave, MSB first.
MISO  input  1  serial data from slave.

Behaviour:
- Reset (async, immediate): SS_n=1, MOSI=0, done=0, rd_data=8'h00, state=IDLE (cmd_ready=1, busy=0). Reset mid-frame aborts the command: SS_n rises at once, no done pulse, no RAM-side guarantee.
- On acceptance, cmd_wr/addr/wdata are registered; later input changes have no effect.
- Frame word = {cmd[1:0], payload[7:0]}:
  - Write: frame A = 2'b00 + addr, frame B = 2'b01 + wdata.
  - Read: frame A = 2'b10 + addr, frame B = 2'b11 + 8'h00.
- FSM states and sequence: IDLE -> START -> SHIFT -> (WAIT -> CAPTURE, only on a read frame B) -> GAP -> START (next frame) or IDLE.
  - START: 1 cycle; SS_n=0; MOSI=bit9 of the frame (lead bit).
  - SHIFT: 10 cycles; SS_n=0; MOSI=bit9..bit0, one bit per cycle; 4-bit counter.
  - WAIT: RD_WAIT cycles; SS_n=0; MOSI=0.
  - CAPTURE: 8 cycles; SS_n=0; MISO sampled at the rising edge ending each cycle and shifted into a register, MSB first.
  - GAP: GAP_CYCLES cycles; SS_n=1; MOSI=0. After frame A, go to START for frame B. After frame B, go to IDLE.
- done pulses in the first GAP cycle after frame B. On a read, rd_data updates in that same cycle.
- Timing with defaults, acceptance edge = cycle 0:
  - Write: frame A SS_n low cycles 1-11; frame B low cycles 14-24; done at 25; cmd_ready high again at 27.
  - Read: frame B shift ends at 24; WAIT 25-26; CAPTURE 27-34; done and rd_data at 35; cmd_ready at 37.
- cmd_valid while busy: ignored, not queued. Back-to-back commands: the next one is accepted on the first IDLE cycle; minimum SS_n-high gap = GAP_CYCLES + 1.
- MISO is ignored outside CAPTURE.

Test Plan:
- Reset: assert rst mid-sequence -> SS_n=1, MOSI=0, done=0, rd_data=8'h00, cmd_ready=1 at once; no done pulse afterwards.
- Write addr 8'h3C, data 8'hA5 -> MOSI frame A = 0000111100, frame B = 0110100101, each preceded by its lead bit; SS_n windows at cycles 1-11 and 14-24; done at 25; RAM model holds mem[8'h3C]=8'hA5.
- Read addr 8'h3C after that write, with the slave/RAM model on MISO -> frame A = 1000111100, frame B = 1100000000; done at 35 with rd_data=8'hA5.
- Held cmd_valid with two queued commands (write 8'h01<-8'h11, then read 8'h01) -> second accepted only on the first IDLE cycle after the first; cmd_ready=0 throughout; read returns 8'h11.
- cmd_valid pulsed while busy with a different addr -> ignored; exactly one done pulse; MOSI reflects only the first command.
- ADDR_SIZE=4, RD_WAIT=3, addr 4'hF -> frame A payload = 8'h0F; first MISO sample one cycle later than the default (cycle 28).
